// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator core: control-register bit map and
// the partial-sum accumulator FSM encoding.
package accel_pkg;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_RELU      = 1;
  localparam int CTRL_SAT       = 2;
  localparam int CTRL_SHIFT_LSB = 4;
  localparam int CTRL_SHIFT_W   = 5;

  typedef enum logic [0:0] {
    ST_DISABLED = 1'b0,
    ST_ACCUM    = 1'b1
  } acc_state_e;

endpackage

// File: rtl/psum_acc_lane.sv
// One kernel lane: signed accumulator with overflow detection, arithmetic
// shift, optional ReLU, saturate-or-wrap requantization and a sticky flag.
module psum_acc_lane
  import accel_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 accept_i,
  input  logic                 last_i,
  input  logic                 relu_i,
  input  logic                 sat_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  input  logic [IN_WIDTH-1:0]  psum_i,
  output logic [OUT_WIDTH-1:0] result_o,
  output logic                 sat_flag_o
);

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] in_ext_s, sum_s, shifted_s, relu_s, out_ext_s;
  logic                        ovf_s, clamp_s;
  logic                        flag_q, flag_d;
  logic [OUT_WIDTH-1:0]        result_s;

  // Add, overflow detect and requantize the running sum including this beat.
  always_comb begin
    in_ext_s  = {{(ACC_WIDTH - IN_WIDTH){psum_i[IN_WIDTH-1]}}, psum_i};
    sum_s     = acc_q + in_ext_s;
    ovf_s     = (acc_q[ACC_WIDTH-1] == in_ext_s[ACC_WIDTH-1]) &&
                (sum_s[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    shifted_s = sum_s >>> shift_i;
    out_ext_s = '0;
    if (relu_i && shifted_s[ACC_WIDTH-1]) begin
      relu_s = '0;
    end else begin
      relu_s = shifted_s;
    end
    if (sat_i) begin
      if (relu_s > OUT_MAX) begin
        result_s = OUT_MAX[OUT_WIDTH-1:0];
        clamp_s  = 1'b1;
      end else if (relu_s < OUT_MIN) begin
        result_s = OUT_MIN[OUT_WIDTH-1:0];
        clamp_s  = 1'b1;
      end else begin
        result_s = relu_s[OUT_WIDTH-1:0];
        clamp_s  = 1'b0;
      end
    end else begin
      result_s  = relu_s[OUT_WIDTH-1:0];
      out_ext_s = {{(ACC_WIDTH - OUT_WIDTH){result_s[OUT_WIDTH-1]}}, result_s};
      clamp_s   = (out_ext_s != relu_s);
    end
  end

  // Next accumulator value and sticky flag; flush beats everything else.
  always_comb begin
    acc_d  = acc_q;
    flag_d = flag_q;
    if (flush_i) begin
      acc_d  = '0;
      flag_d = 1'b0;
    end else if (accept_i) begin
      acc_d  = last_i ? '0 : sum_s;
      flag_d = flag_q | ovf_s | (last_i & clamp_s);
    end else begin
      acc_d  = acc_q;
      flag_d = flag_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      flag_q <= flag_d;
    end
  end

  assign result_o   = result_s;
  assign sat_flag_o = flag_q;

endmodule

// File: rtl/psum_accumulator_nk.sv
// NUM_KERNEL-lane partial-sum accumulator: FSM, pass counter, per-group
// config latch and valid/ready output register around the lane datapaths.
module psum_accumulator_nk
  import accel_pkg::*;
#(
  parameter int NUM_KERNEL = 4,
  parameter int IN_WIDTH   = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int REG_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]             i_conf_cnt,
  input  logic [NUM_KERNEL*IN_WIDTH-1:0]   i_psum,
  input  logic                             i_psum_val,
  output logic                             o_psum_rdy,
  output logic [NUM_KERNEL*OUT_WIDTH-1:0]  o_psum,
  output logic                             o_psum_val,
  input  logic                             i_out_rdy,
  output logic [NUM_KERNEL-1:0]            o_sat_flag,
  output logic                             o_busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  acc_state_e                       state_q, state_d;
  logic [CNT_WIDTH-1:0]             cnt_q, cnt_d, n_lat_q, n_lat_d;
  logic [CNT_WIDTH-1:0]             cfg_n_s, n_eff_s;
  logic                             relu_q, relu_d, sat_q, sat_d;
  logic [CTRL_SHIFT_W-1:0]          shift_q, shift_d, shift_eff_s;
  logic [NUM_KERNEL*OUT_WIDTH-1:0]  psum_q, psum_d, lane_res_s;
  logic                             val_q, val_d;
  logic                             en_s, flush_s, rdy_s, first_s, accept_s, last_s, load_s;
  logic                             relu_eff_s, sat_eff_s;
  logic                             conf_unused_s;

  assign conf_unused_s = ^{i_conf_ctrl[REG_WIDTH-1:CTRL_SHIFT_LSB+CTRL_SHIFT_W],
                           i_conf_ctrl[CTRL_SHIFT_LSB-1:CTRL_SAT+1],
                           i_conf_cnt[REG_WIDTH-1:CNT_WIDTH]};

  assign en_s     = i_conf_ctrl[CTRL_EN];
  assign flush_s  = (state_q == ST_ACCUM) && !en_s;
  assign rdy_s    = (state_q == ST_ACCUM) && (!val_q || i_out_rdy);
  assign accept_s = i_psum_val && rdy_s && !flush_s;
  assign first_s  = (cnt_q == '0);
  assign cfg_n_s  = (i_conf_cnt[CNT_WIDTH-1:0] == '0) ? CNT_ONE : i_conf_cnt[CNT_WIDTH-1:0];

  // The first beat of a group uses the live config; later beats the latched copy.
  assign n_eff_s     = first_s ? cfg_n_s : n_lat_q;
  assign relu_eff_s  = first_s ? i_conf_ctrl[CTRL_RELU] : relu_q;
  assign sat_eff_s   = first_s ? i_conf_ctrl[CTRL_SAT] : sat_q;
  assign shift_eff_s = first_s ? i_conf_ctrl[CTRL_SHIFT_LSB +: CTRL_SHIFT_W] : shift_q;
  assign last_s      = (cnt_q == (n_eff_s - CNT_ONE));
  assign load_s      = accept_s && last_s;

  genvar k;
  generate
    for (k = 0; k < NUM_KERNEL; k++) begin : g_lane
      psum_acc_lane #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT_W   (CTRL_SHIFT_W)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst),
        .flush_i    (flush_s),
        .accept_i   (accept_s),
        .last_i     (last_s),
        .relu_i     (relu_eff_s),
        .sat_i      (sat_eff_s),
        .shift_i    (shift_eff_s),
        .psum_i     (i_psum[k*IN_WIDTH +: IN_WIDTH]),
        .result_o   (lane_res_s[k*OUT_WIDTH +: OUT_WIDTH]),
        .sat_flag_o (o_sat_flag[k])
      );
    end
  endgenerate

  // Enable-driven state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: state_d = en_s ? ST_ACCUM : ST_DISABLED;
      ST_ACCUM:    state_d = en_s ? ST_ACCUM : ST_DISABLED;
      default:     state_d = ST_DISABLED;
    endcase
  end

  // Counter, config latch and output handshake next-state.
  always_comb begin
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    relu_d  = relu_q;
    sat_d   = sat_q;
    shift_d = shift_q;
    psum_d  = psum_q;
    val_d   = val_q;
    if (flush_s) begin
      cnt_d = '0;
      val_d = 1'b0;
    end else begin
      if (accept_s && first_s) begin
        n_lat_d = cfg_n_s;
        relu_d  = relu_eff_s;
        sat_d   = sat_eff_s;
        shift_d = shift_eff_s;
      end else begin
        n_lat_d = n_lat_q;
      end
      if (accept_s) begin
        cnt_d = last_s ? '0 : (cnt_q + CNT_ONE);
      end else begin
        cnt_d = cnt_q;
      end
      if (load_s) begin
        psum_d = lane_res_s;
        val_d  = 1'b1;
      end else if (i_out_rdy) begin
        val_d = 1'b0;
      end else begin
        val_d = val_q;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_DISABLED;
      cnt_q   <= '0;
      n_lat_q <= '0;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
      shift_q <= '0;
      psum_q  <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
      relu_q  <= relu_d;
      sat_q   <= sat_d;
      shift_q <= shift_d;
      psum_q  <= psum_d;
      val_q   <= val_d;
    end
  end

  assign o_psum_rdy = rdy_s;
  assign o_psum     = psum_q;
  assign o_psum_val = val_q;
  assign o_busy     = (cnt_q != '0);

endmodule

// File: tb/tb_psum_accumulator_nk.sv
// Scoreboard bench for psum_accumulator_nk: directed beats push expected
// results; a negedge monitor pops and compares on every output transfer.
module tb_psum_accumulator_nk;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_conf_ctrl = 32'd0;
  logic [31:0] i_conf_cnt = 32'd0;
  logic [31:0] i_psum = 32'd0;
  logic        i_psum_val = 1'b0;
  logic        o_psum_rdy;
  logic [31:0] o_psum;
  logic        o_psum_val;
  logic        i_out_rdy = 1'b1;
  logic [3:0]  o_sat_flag;
  logic        o_busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  psum_accumulator_nk dut (
    .clk        (clk),
    .rst        (rst),
    .i_conf_ctrl(i_conf_ctrl),
    .i_conf_cnt (i_conf_cnt),
    .i_psum     (i_psum),
    .i_psum_val (i_psum_val),
    .o_psum_rdy (o_psum_rdy),
    .o_psum     (o_psum),
    .o_psum_val (o_psum_val),
    .i_out_rdy  (i_out_rdy),
    .o_sat_flag (o_sat_flag),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] cf(input int en, input int relu, input int sat, input int shift);
    return 32'(en) | (32'(relu) << 1) | (32'(sat) << 2) | (32'(shift) << 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one beat and hold it until the DUT takes it.
  task automatic beat(input logic [31:0] v);
    int waited;
    waited = 0;
    i_psum     = v;
    i_psum_val = 1'b1;
    forever begin
      @(negedge clk);
      if (o_psum_rdy) break;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_timeout: rdy stuck low for beat %h", v);
        break;
      end
    end
    @(posedge clk); #1;
    i_psum_val = 1'b0;
  endtask

  // Let pending results drain, then drop enable for one cycle.
  task automatic reconfig(input logic [31:0] ctrl);
    repeat (2) @(posedge clk);
    #1;
    i_conf_ctrl = 32'd0;
    @(posedge clk); #1;
    chk("flush_busy", 32'(o_busy), 32'd0);
    chk("flush_val", 32'(o_psum_val), 32'd0);
    chk("flush_flag", 32'(o_sat_flag), 32'd0);
    i_conf_ctrl = ctrl;
  endtask

  // Scoreboard monitor: a transfer happens at the next edge when val && rdy.
  always @(negedge clk) begin
    if (rst && o_psum_val && i_out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got %h expected none", o_psum);
      end else begin
        chk("result", o_psum, exp_q.pop_front());
      end
    end
  end

  initial begin
    #12;
    chk("rst_psum", o_psum, 32'd0);
    chk("rst_val", 32'(o_psum_val), 32'd0);
    chk("rst_flag", 32'(o_sat_flag), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_rdy", 32'(o_psum_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic accumulation: 10+20+30
    i_conf_ctrl = cf(1, 0, 1, 0);
    i_conf_cnt  = 32'd3;
    beat(pk(10, 0, 0, 0));
    chk("busy_mid", 32'(o_busy), 32'd1);
    beat(pk(20, 0, 0, 0));
    chk("val_before_last", 32'(o_psum_val), 32'd0);
    exp_q.push_back(pk(60, 0, 0, 0));
    beat(pk(30, 0, 0, 0));
    chk("latency_val", 32'(o_psum_val), 32'd1);
    chk("cnt_back_zero", 32'(o_busy), 32'd0);
    chk("no_flag", 32'(o_sat_flag), 32'd0);

    // Saturation then wrap on lane1: 100+100
    i_conf_cnt = 32'd2;
    beat(pk(0, 100, 0, 0));
    exp_q.push_back(pk(0, 127, 0, 0));
    beat(pk(0, 100, 0, 0));
    chk("sat_flag", 32'(o_sat_flag), 32'd2);
    reconfig(cf(1, 0, 0, 0));
    beat(pk(0, 100, 0, 0));
    exp_q.push_back(pk(0, -56, 0, 0));
    beat(pk(0, 100, 0, 0));
    chk("wrap_flag", 32'(o_sat_flag), 32'd2);

    // ReLU and arithmetic shift on lane2
    reconfig(cf(1, 1, 1, 0));
    i_conf_cnt = 32'd1;
    exp_q.push_back(pk(0, 0, 0, 0));
    beat(pk(0, 0, -5, 0));
    i_conf_ctrl = cf(1, 0, 1, 1);
    exp_q.push_back(pk(0, 0, -3, 0));
    beat(pk(0, 0, -5, 0));
    chk("shift_no_flag", 32'(o_sat_flag), 32'd0);

    // Back-pressure with N=1 and a continuous stream
    repeat (3) @(posedge clk);
    #1;
    i_conf_ctrl = cf(1, 0, 1, 0);
    i_out_rdy   = 1'b0;
    i_psum      = pk(1, 0, 0, 0);
    i_psum_val  = 1'b1;
    exp_q.push_back(pk(1, 0, 0, 0));
    @(posedge clk); #1;
    chk("bp_val", 32'(o_psum_val), 32'd1);
    i_psum = pk(2, 0, 0, 0);
    exp_q.push_back(pk(2, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(o_psum_rdy), 32'd0);
      chk("bp_hold", o_psum, pk(1, 0, 0, 0));
    end
    @(posedge clk); #1;
    i_out_rdy = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("bp_stream_val", 32'(o_psum_val), 32'd1);
      i_psum = pk(k, 0, 0, 0);
      exp_q.push_back(pk(k, 0, 0, 0));
    end
    @(posedge clk); #1;
    i_psum_val = 1'b0;

    // Mid-group count change is ignored until the next group
    repeat (3) @(posedge clk);
    #1;
    i_conf_cnt = 32'd4;
    beat(pk(1, 0, 0, 0));
    i_conf_cnt = 32'd2;
    beat(pk(2, 0, 0, 0));
    beat(pk(3, 0, 0, 0));
    chk("midcfg_no_out", 32'(o_psum_val), 32'd0);
    chk("midcfg_busy", 32'(o_busy), 32'd1);
    exp_q.push_back(pk(10, 0, 0, 0));
    beat(pk(4, 0, 0, 0));
    beat(pk(5, 0, 0, 0));
    exp_q.push_back(pk(11, 0, 0, 0));
    beat(pk(6, 0, 0, 0));

    // Enable dropped mid-group, then a fresh group of three ones
    i_conf_cnt = 32'd3;
    beat(pk(1, 0, 0, 0));
    beat(pk(1, 0, 0, 0));
    reconfig(cf(1, 0, 1, 0));
    chk("flush_rdy", 32'(o_psum_rdy), 32'd0);
    beat(pk(1, 0, 0, 0));
    beat(pk(1, 0, 0, 0));
    exp_q.push_back(pk(3, 0, 0, 0));
    beat(pk(1, 0, 0, 0));

    // Set a flag on lane3, start a group, then async reset mid-cycle
    i_conf_cnt = 32'd2;
    beat(pk(0, 0, 0, 100));
    exp_q.push_back(pk(0, 0, 0, 127));
    beat(pk(0, 0, 0, 100));
    chk("lane3_flag", 32'(o_sat_flag), 32'd8);
    repeat (2) @(posedge clk);
    #1;
    i_conf_cnt = 32'd3;
    beat(pk(1, 0, 0, 0));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_val", 32'(o_psum_val), 32'd0);
    chk("arst_psum", o_psum, 32'd0);
    chk("arst_flag", 32'(o_sat_flag), 32'd0);
    chk("arst_rdy", 32'(o_psum_rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psum_accumulator_nk.md
Name: psum_accumulator_nk

Overview:
- Parametrised successor to the fixed 4-kernel, 8-bit partial-sum accumulator that sits behind line_kcpe_conv2d_engine inside the accelerator core.
- Accumulates NUM_KERNEL lanes of signed partial sums over a run-time count of passes, then requantizes each lane: arithmetic shift, optional ReLU, saturate or wrap.
- Presents results on a valid/ready output with back-pressure toward the engine.

Parameters:
- NUM_KERNEL, 4, number of parallel kernel lanes.
- IN_WIDTH, 8, signed input psum width per lane.
- ACC_WIDTH, 20, signed accumulator width per lane (must be >= IN_WIDTH + ceil(log2(max count))).
- OUT_WIDTH, 8, signed output width per lane.
- CNT_WIDTH, 16, width of the pass counter.
- REG_WIDTH, 32, configuration register width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- i_conf_ctrl  in  REG_WIDTH  control bits:
  - bit0 enable
  - bit1 relu
  - bit2 saturate (1) / wrap (0)
  - bits[8:4] right-shift amount SHIFT
- i_conf_cnt  in  REG_WIDTH  [CNT_WIDTH-1:0] = N, psums per output; N=0 is treated as 1.
- i_psum  in  NUM_KERNEL*IN_WIDTH  packed lane psums, lane k at [k*IN_WIDTH +: IN_WIDTH].
- i_psum_val  in  1  input beat valid, all lanes together.
- o_psum_rdy  out  1  accumulator can accept a beat.
- o_psum  out  NUM_KERNEL*OUT_WIDTH  packed results.
- o_psum_val  out  1  result valid.
- i_out_rdy  in  1  downstream accepts result.
- o_sat_flag  out  NUM_KERNEL  sticky per-lane saturation/overflow flag.
- o_busy  out  1  a group is partially accumulated (cnt != 0).

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state go to zero:
  - acc, cnt, o_psum=0
  - o_psum_val=0, o_sat_flag=0, o_busy=0
  - state=DISABLED
- FSM states: DISABLED, ACCUM.
  - DISABLED -> ACCUM when enable=1.
  - ACCUM -> DISABLED when enable=0. This is a synchronous flush next cycle: acc, cnt, o_psum_val and o_sat_flag cleared. o_psum is not cleared.
- o_psum_rdy = (state==ACCUM) & (~o_psum_val | i_out_rdy). Combinational, no dependency on i_psum_val.
- Accept = i_psum_val & o_psum_rdy.
- N_lat and cfg_lat:
  - When cnt==0, N_lat, relu, sat and SHIFT are taken from the config on the accepting beat and held for the group.
  - Config changes mid-group have no effect until the next group.
- On accept:
  - If cnt == N_lat-1 (last beat): result_k = acc_k + sext(in_k); o_psum/o_psum_val load next cycle; acc_k <= 0; cnt <= 0.
  - Otherwise: acc_k <= acc_k + sext(in_k); cnt <= cnt+1.
- Latency: last input accepted at cycle t -> o_psum_val=1 at t+1.
- Output register: held stable while o_psum_val & ~i_out_rdy. o_psum_val clears on i_out_rdy unless a new last beat is accepted in the same cycle (back-to-back). With N=1, throughput is 1 result/cycle.
- Requantization per lane (combinational, before the output register):
  - s = result >>> SHIFT (arithmetic). SHIFT >= ACC_WIDTH yields 0 or -1 by sign.
  - If relu and s<0, s=0.
  - If sat: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. If clamping occurred, set o_sat_flag[k].
  - Else truncate to OUT_WIDTH LSBs. If the truncated value != s, set o_sat_flag[k].
- Accumulator overflow (ACC_WIDTH signed wrap on add) also sets o_sat_flag[k]. The accumulator itself wraps.
- o_sat_flag is sticky until flush or reset.
- Input held with i_psum_val=1 while o_psum_rdy=0: no accept, no state change.

Decomposition:
- Package accel_pkg:
  - ctrl bit positions CTRL_EN=0, CTRL_RELU=1, CTRL_SAT=2, CTRL_SHIFT_LSB=4, CTRL_SHIFT_W=5.
  - FSM state encoding.
- Sub-module psum_acc_lane: one lane's accumulator register, add/overflow detect, shift/ReLU/saturate, sticky flag. Instantiated NUM_KERNEL times via generate.
- The top holds the FSM, counter, config latch and output handshake.

Test Plan:
- N=3, SHIFT=0, sat, lane0 inputs 10,20,30 -> o_psum lane0=60, o_psum_val one cycle after 3rd accept, cnt back to 0.
- N=2, lane1 inputs 100,100, sat, OUT_WIDTH=8 -> output 127, o_sat_flag[1]=1. Same with wrap -> output -56 (0xC8), flag=1.
- N=1, relu, lane2 input -5 -> output 0. No relu, SHIFT=1, input -5 -> output -3.
- N=1, continuous i_psum_val, i_out_rdy low for 3 cycles:
  - o_psum_rdy=0 while o_psum_val=1, output stable.
  - After i_out_rdy=1, one result/cycle, no beat lost or duplicated.
- Mid-group change N=4->2 after 1st beat -> group completes after 4 beats. Next group uses N=2.
- Enable dropped after 2 of 3 beats -> next cycle cnt=0, o_busy=0, o_psum_val=0. Re-enable then 3 beats of 1 -> output 3. Async rst=0 mid-group -> all outputs 0 immediately.
